// File: rtl/sram_arbiter.sv
// Two-master SRAM-like bus arbiter: inst and data ports share one memory port,
// one transaction outstanding, data preferred with an anti-starvation limit for inst.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic [1:0]  state_dbg,
  output logic [3:0]  starve_cnt
);

  // Handshake: a request phase completes in the cycle where req=1 and addr_ok=1;
  // the response completes in the cycle where data_ok=1 (rdata valid only then).
  // Requesters hold their fields stable from req rising until their addr_ok.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       grant_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    grant_data   = data_req && !(inst_req && (starve_cnt_q == LIMIT));
    case (state_q)
      S_IDLE: begin
        if (inst_req || data_req) begin
          state_d = S_ADDR;
          owner_d = grant_data;
          // Count only data grants that made a waiting inst request lose.
          if (grant_data && inst_req) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end
      end
      S_ADDR: begin
        if (mem_addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Request fields follow the owner live; mem_req alone qualifies them.
  assign mem_req   = (state_q == S_ADDR);
  assign mem_wr    = owner_q ? data_wr    : inst_wr;
  assign mem_size  = owner_q ? data_size  : inst_size;
  assign mem_wstrb = owner_q ? data_wstrb : inst_wstrb;
  assign mem_addr  = owner_q ? data_addr  : inst_addr;
  assign mem_wdata = owner_q ? data_wdata : inst_wdata;

  assign inst_addr_ok = (state_q == S_ADDR) && !owner_q && mem_addr_ok;
  assign data_addr_ok = (state_q == S_ADDR) &&  owner_q && mem_addr_ok;
  assign inst_data_ok = (state_q == S_DATA) && !owner_q && mem_data_ok;
  assign data_data_ok = (state_q == S_DATA) &&  owner_q && mem_data_ok;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign owner      = owner_q;
  assign state_dbg  = state_q;
  assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a transaction-level bus model predicts each
// cycle's handshake outputs and each granted request; a monitor compares them.
module tb_sram_arbiter;

  localparam int LIMIT = 4;
  localparam int CW    = 74;
  localparam int TW    = 72;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [3:0]  inst_wstrb = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        owner;
  logic [1:0]  state_dbg;
  logic [3:0]  starve_cnt;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .owner(owner), .state_dbg(state_dbg), .starve_cnt(starve_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [CW-1:0] exp_q[$];
  logic [TW-1:0] txn_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Stimulus knobs (percent)
  int p_req = 0, p_aok = 0, p_dok = 0, p_wd = 0, p_rst = 0;

  // Bus model: slot phase 0=free, 1=request phase, 2=response phase
  int         m_phase = 0;
  logic       m_owner = 1'b0;
  logic [3:0] m_starve = 4'd0;
  bit         rel_i = 0, rel_d = 0;

  task automatic report_fail(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_err++;
    if (n_err <= 20) $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
  endtask

  task automatic step(input bit rst);
    logic e_mreq, ei_a, ei_d, ed_a, ed_d;
    bit   win_d;
    @(posedge clk);
    #1;
    resetn = !rst;
    if (rel_i) begin inst_req = 1'b0; rel_i = 0; end
    if (rel_d) begin data_req = 1'b0; rel_d = 0; end
    if (!inst_req && $urandom_range(99) < p_req) begin
      inst_req = 1'b1; inst_wr = 1'($urandom); inst_size = 2'($urandom);
      inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
    end else if (inst_req && !(m_phase == 1 && !m_owner) && $urandom_range(99) < p_wd) begin
      inst_req = 1'b0;
    end
    if (!data_req && $urandom_range(99) < p_req) begin
      data_req = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom);
      data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
    end else if (data_req && !(m_phase == 1 && m_owner) && $urandom_range(99) < p_wd) begin
      data_req = 1'b0;
    end
    mem_addr_ok = ($urandom_range(99) < p_aok);
    mem_data_ok = ($urandom_range(99) < p_dok);
    mem_rdata   = $urandom;

    if (rst) begin
      m_phase = 0; m_owner = 1'b0; m_starve = 4'd0;
    end
    e_mreq = !rst && (m_phase == 1);
    ei_a = e_mreq && !m_owner && mem_addr_ok;
    ed_a = e_mreq &&  m_owner && mem_addr_ok;
    ei_d = !rst && (m_phase == 2) && !m_owner && mem_data_ok;
    ed_d = !rst && (m_phase == 2) &&  m_owner && mem_data_ok;
    exp_q.push_back({e_mreq, ei_a, ei_d, ed_a, ed_d, m_owner, m_starve, mem_rdata, mem_rdata});

    if (!rst) begin
      case (m_phase)
        0: if (inst_req || data_req) begin
          win_d = data_req && !(inst_req && m_starve == 4'(LIMIT));
          if (win_d) txn_q.push_back({1'b1, data_wr, data_size, data_wstrb, data_addr, data_wdata});
          else       txn_q.push_back({1'b0, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata});
          m_starve = (win_d && inst_req) ? m_starve + 4'd1 : 4'd0;
          m_owner  = win_d;
          m_phase  = 1;
        end
        1: if (mem_addr_ok) begin
          if (m_owner) rel_d = 1; else rel_i = 1;
          m_phase = 2;
        end
        default: if (mem_data_ok) m_phase = 0;
      endcase
    end
  endtask

  // Monitor: per-cycle outputs, plus request fields at each address handshake
  initial begin
    logic [CW-1:0] e, a;
    logic [TW-1:0] t, at;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
             owner, starve_cnt, inst_rdata, data_rdata};
        n_cmp++;
        if (a !== e) report_fail("cycle_outputs", 128'(a), 128'(e));
      end
      if (mem_req === 1'b1 && mem_addr_ok === 1'b1) begin
        at = {data_addr_ok, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
        n_cmp++;
        if (txn_q.size() == 0) begin
          report_fail("unexpected_grant", 128'(at), 128'(0));
        end else begin
          t = txn_q.pop_front();
          if (at !== t) report_fail("grant_fields", 128'(at), 128'(t));
        end
      end
    end
  end

  // Test sequence
  initial begin
    for (int i = 0; i < 3; i++) step(1);
    // Both masters saturating, memory answering at once: exercises the starvation cap
    p_req = 100; p_aok = 100; p_dok = 100; p_wd = 0; p_rst = 0;
    for (int i = 0; i < 60; i++) step(0);
    // Random traffic with stalls, spurious data_ok and withdrawn requests
    p_req = 30; p_aok = 45; p_dok = 45; p_wd = 10;
    for (int i = 0; i < 600; i++) step(0);
    // Same, with resets landing during the response phase
    p_rst = 15;
    for (int i = 0; i < 600; i++) step((m_phase == 2) && ($urandom_range(99) < p_rst));
    // Drain everything still pending
    p_req = 0; p_aok = 100; p_dok = 100; p_wd = 0; p_rst = 0;
    for (int i = 0; i < 20; i++) step(0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (txn_q.size() != 0) report_fail("grants_left_over", 128'(txn_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, max consecutive data grants while inst_req is pending before inst is forced to win (range 1..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have inst-side ports: inst_req in 1; inst_wr in 1; inst_size in 2; inst_wstrb in 4; inst_addr in 32; inst_wdata in 32; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-005 SHALL have data-side ports: data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok and data_rdata, with the same directions and widths as the inst side.
REQ-006 SHALL have memory-side ports: mem_req out 1; mem_wr out 1; mem_size out 2; mem_wstrb out 4; mem_addr out 32; mem_wdata out 32; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in 32.
REQ-007 SHALL have port: owner  out  1  current grant holder (0 = inst, 1 = data); debug only.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, ADDR, DATA; at most one memory transaction outstanding.
REQ-009 In IDLE with any request present, SHALL pick a winner, register it into owner, and go to ADDR on the next edge; grant latency is 1 cycle after the request is first seen in IDLE.
REQ-010 Arbitration SHALL be: data wins when both request, unless starve_cnt == STARVE_LIMIT, in which case inst wins; a lone requester always wins.
REQ-011 starve_cnt (4 bits) SHALL increment on a data grant made while inst_req=1, clear on any inst grant, clear on a data grant made while inst_req=0, and never exceed STARVE_LIMIT.
REQ-012 In ADDR, SHALL drive mem_req=1, with mem_wr/size/wstrb/addr/wdata muxed live from the owner's inputs; requesters hold their fields stable until their addr_ok.
REQ-013 In ADDR, <owner>_addr_ok SHALL equal mem_addr_ok combinationally; on mem_addr_ok=1 the FSM SHALL go to DATA.
REQ-014 In DATA, SHALL drive mem_req=0 and <owner>_data_ok = mem_data_ok; on mem_data_ok=1 the FSM SHALL go to IDLE.
REQ-015 inst_rdata and data_rdata SHALL both be wired directly to mem_rdata; only data_ok qualifies the data.
REQ-016 The non-owner's addr_ok and data_ok SHALL be 0 at all times; in IDLE, all addr_ok, data_ok and mem_req outputs SHALL be 0.
REQ-017 mem_data_ok asserted in IDLE or ADDR SHALL be ignored, with no state change and no data_ok pulse.
REQ-018 A request withdrawn in IDLE before it is granted SHALL be dropped silently; a requester deasserting req in ADDR is a protocol violation and SHALL NOT be checked.
REQ-019 A new arbitration SHALL occur only in IDLE, so the minimum transaction period is 3 cycles (IDLE→ADDR→DATA→IDLE) when addr_ok and data_ok each arrive on their first eligible cycle.

Reset
REQ-020 resetn=0 SHALL immediately and asynchronously force: state=IDLE, owner=0, starve_cnt=0.
REQ-021 During reset, mem_req and all four addr_ok/data_ok outputs SHALL read 0.
REQ-022 Reset asserted mid-transaction (ADDR or DATA) SHALL abandon it; after release, the first arbitration proceeds as from power-up.
REQ-023 The first grant SHALL occur no earlier than the first rising edge with resetn=1.

Verification
REQ-024 Lone inst read: inst_req=1, inst_addr=0xBFC00000; mem_addr_ok on cycle 2, mem_data_ok on cycle 3 with mem_rdata=0x3C1DA000 → inst_addr_ok pulses cycle 2; inst_data_ok pulses cycle 3 with inst_rdata=0x3C1DA000; data_* ok outputs stay 0.
REQ-025 Simultaneous: inst_req=data_req=1 continuously, memory answers immediately, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt sequence 1,2,3,4,0.
REQ-026 Data write: data_wr=1, data_wstrb=4'b0011, data_addr=0x1FAF0000, data_wdata=0x12345678; memory holds mem_addr_ok=0 for 3 cycles → mem_req stays 1 and fields stay stable for 3 cycles; data_addr_ok pulses exactly once.
REQ-027 Spurious mem_data_ok=1 in IDLE and during ADDR → no data_ok pulse, state unchanged.
REQ-028 resetn=0 in DATA for 1 cycle then released, with data_req=1 held → all outputs 0 during reset; data is re-granted 1 cycle after release; starve_cnt restarts at 0.
REQ-029 inst_req pulsed for 1 cycle while the FSM is in DATA serving data → no inst grant occurs; the FSM returns to IDLE and stays there.
